button_bounce_emulator: RTL and testbench

Generates a realistic bouncing raw push-button waveform from a clean one-cycle press request. It is the driving end of the button-input path, producing the noisy signal that the button debouncer consumes. It is used in on-board self-test and in simulation benches, where it replaces a physical button on the pong control inputs. Bounce timing is pseudo-random and comes from an internal 16-bit LFSR, so the output is deterministic from reset.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/lfsr16.sv | 25 ++
 rtl/button_bounce_emulator.sv | 149 ++++++++++++++
 tb/tb_button_bounce_emulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong button-input path: bounce emulator state
// encoding and the 16-bit LFSR polynomial used by the random sources.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        HOLD           = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        SETTLE         = 3'd4
    } bounce_state_t;

    // Fibonacci taps 16,14,13,11 map to register bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left every cycle out of reset.
// Shared by the bounce emulator and the ball-serve randomiser.
module lfsr16
    import pong_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    if (SEED == 16'h0000) begin : g_seed_check
        $error("lfsr16: SEED must be nonzero");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/button_bounce_emulator.sv
// Turns a one-cycle press request into a noisy press/hold/release/settle
// waveform on raw_button, with LFSR-driven gaps between bounce toggles.
module button_bounce_emulator
    import pong_pkg::*;
#(
    parameter int unsigned BOUNCE_PAIRS  = 8,
    parameter int unsigned GAP_LOG2      = 10,
    parameter int unsigned HOLD_CYCLES   = 500000,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_LFSR_SEED
) (
    input  logic clk,
    input  logic rst_n,
    input  logic press_req,
    output logic raw_button,
    output logic busy,
    output logic done
);

    localparam int unsigned TOGGLES  = 2 * BOUNCE_PAIRS + 1;
    localparam int unsigned TOG_W    = $clog2(TOGGLES + 1);
    localparam int unsigned GAP_W    = GAP_LOG2 + 1;
    localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TOG_W-1:0]    TOG_ONE     = TOG_W'(1);
    localparam logic [TOG_W-1:0]    TOG_PENULT  = TOG_W'(TOGGLES - 1);
    localparam logic [GAP_W-1:0]    GAP_ONE     = GAP_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES);

    if (LFSR_SEED == 16'h0000 || HOLD_CYCLES == 0 || SETTLE_CYCLES == 0 ||
        GAP_LOG2 == 0 || GAP_LOG2 > 16) begin : g_param_check
        $error("button_bounce_emulator: illegal parameter combination");
    end

    bounce_state_t         state;
    logic [TOG_W-1:0]      toggle_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [15:0]           lfsr_q;
    logic [GAP_W-1:0]      gap_load;
    logic                  lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (lfsr_q)
    );

    // One extra bit so that an all-ones LFSR slice yields 2^GAP_LOG2, not 0.
    assign gap_load    = {1'b0, lfsr_q[GAP_LOG2-1:0]} + GAP_ONE;
    assign lfsr_unused = ^lfsr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            raw_button <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            toggle_cnt <= '0;
            gap_cnt    <= '0;
            hold_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_req) begin
                        raw_button <= 1'b1;
                        busy       <= 1'b1;
                        toggle_cnt <= TOG_ONE;
                        if (TOGGLES == 1) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_ONE;
                        end else begin
                            state   <= PRESS_BOUNCE;
                            gap_cnt <= gap_load;
                        end
                    end
                end

                // The final toggle of each phase hands over to the stable phase,
                // which counts that toggle cycle as its first cycle.
                PRESS_BOUNCE, RELEASE_BOUNCE: begin
                    if (gap_cnt == GAP_ONE) begin
                        raw_button <= ~raw_button;
                        if (toggle_cnt == TOG_PENULT) begin
                            toggle_cnt <= '0;
                            gap_cnt    <= '0;
                            if (state == PRESS_BOUNCE) begin
                                state    <= HOLD;
                                hold_cnt <= HOLD_ONE;
                            end else begin
                                state      <= SETTLE;
                                settle_cnt <= SETTLE_ONE;
                            end
                        end else begin
                            toggle_cnt <= toggle_cnt + TOG_ONE;
                            gap_cnt    <= gap_load;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end

                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        raw_button <= 1'b0;
                        hold_cnt   <= '0;
                        toggle_cnt <= TOG_ONE;
                        if (TOGGLES == 1) begin
                            state      <= SETTLE;
                            settle_cnt <= SETTLE_ONE;
                        end else begin
                            state   <= RELEASE_BOUNCE;
                            gap_cnt <= gap_load;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_ONE;
                    end
                end

                default: begin
                    state      <= IDLE;
                    raw_button <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_bounce_emulator.sv
// Scoreboard bench: stimulus queues expected (cycle, raw, busy, done) events,
// per-DUT monitors pop and compare whenever an output changes or done pulses.
module tb_button_bounce_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // dut_a: no bounce, short hold/settle. dut_b: default bounce timing.
    logic rst_a_n, press_a, raw_a, busy_a, done_a;
    logic rst_b_n, press_b, raw_b, busy_b, done_b;

    button_bounce_emulator #(
        .BOUNCE_PAIRS  (0),
        .GAP_LOG2      (10),
        .HOLD_CYCLES   (10),
        .SETTLE_CYCLES (5),
        .LFSR_SEED     (16'hACE1)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_a_n),
        .press_req  (press_a),
        .raw_button (raw_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    button_bounce_emulator #(
        .BOUNCE_PAIRS  (8),
        .GAP_LOG2      (10),
        .HOLD_CYCLES   (200),
        .SETTLE_CYCLES (1024),
        .LFSR_SEED     (16'hACE1)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_b_n),
        .press_req  (press_b),
        .raw_button (raw_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    logic [43:0] exp_a[$];
    logic [43:0] exp_b[$];

    function automatic logic [43:0] pack_ev(input int c, input logic r, input logic b, input logic d);
        return {c, 3'b000, r, 3'b000, b, 3'b000, d};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic checkOutput(input string name, input logic [43:0] actual, input logic [43:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitUntil(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Press request is high during cycle c, so the first edge shows at c+1.
    task automatic applyStimulus(input bit sel_b, input int c);
        waitUntil(c);
        if (sel_b) press_b = 1'b1; else press_a = 1'b1;
        @(negedge clk);
        press_a = 1'b0;
        press_b = 1'b0;
    endtask

    task automatic push_a_sequence(input int c);
        exp_a.push_back(pack_ev(c + 1, 1'b1, 1'b1, 1'b0));
        exp_a.push_back(pack_ev(c + 11, 1'b0, 1'b1, 1'b0));
        exp_a.push_back(pack_ev(c + 16, 1'b0, 1'b0, 1'b1));
    endtask

    // Predicts every dut_b event for a press at cycle c, LFSR at seed in cycle r.
    task automatic build_expected_b(input int r, input int c, output int done_cyc);
        logic [15:0] l;
        int t;
        int g;
        logic lvl;
        l = 16'hACE1;
        for (int k = r; k < c; k++) l = lfsr_step(l);
        t = c + 1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 1; i <= 17; i++) begin
                lvl = ((i % 2) == 1) ^ (ph == 1);
                exp_b.push_back(pack_ev(t, lvl, 1'b1, 1'b0));
                if (i < 17) begin
                    g = int'(l[9:0]) + 1;
                    for (int k = 0; k < g; k++) l = lfsr_step(l);
                    t += g;
                end
            end
            if (ph == 0) begin
                for (int k = 0; k < 200; k++) l = lfsr_step(l);
                t += 200;
            end
        end
        done_cyc = t + 1024;
        exp_b.push_back(pack_ev(done_cyc, 1'b0, 1'b0, 1'b1));
    endtask

    logic prev_raw_a = 1'b0, prev_busy_a = 1'b0;
    logic prev_raw_b = 1'b0, prev_busy_b = 1'b0;

    always @(negedge clk) begin
        if (raw_a !== prev_raw_a || busy_a !== prev_busy_a || done_a !== 1'b0) begin
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut_a unexpected event: got %h, expected none",
                         pack_ev(cyc, raw_a, busy_a, done_a));
            end else begin
                checkOutput("dut_a event", pack_ev(cyc, raw_a, busy_a, done_a), exp_a.pop_front());
            end
        end
        prev_raw_a  = raw_a;
        prev_busy_a = busy_a;
    end

    always @(negedge clk) begin
        if (raw_b !== prev_raw_b || busy_b !== prev_busy_b || done_b !== 1'b0) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL dut_b unexpected event: got %h, expected none",
                         pack_ev(cyc, raw_b, busy_b, done_b));
            end else begin
                checkOutput("dut_b event", pack_ev(cyc, raw_b, busy_b, done_b), exp_b.pop_front());
            end
        end
        prev_raw_b  = raw_b;
        prev_busy_b = busy_b;
    end

    int done_b1, done_b2, r2;

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        press_a = 1'b0;
        press_b = 1'b0;

        // Three reset edges, then check the reset state before releasing.
        waitUntil(3);
        checkOutput("reset raw_a", 44'(raw_a), 44'(1'b0));
        checkOutput("reset busy_a", 44'(busy_a), 44'(1'b0));
        checkOutput("reset done_a", 44'(done_a), 44'(1'b0));
        checkOutput("reset raw_b", 44'(raw_b), 44'(1'b0));
        checkOutput("reset busy_b", 44'(busy_b), 44'(1'b0));
        checkOutput("reset done_b", 44'(done_b), 44'(1'b0));
        checkOutput("reset lfsr_b", 44'(dut_b.lfsr_q), 44'(16'hACE1));
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // Clean edge, hold 10, settle 5.
        push_a_sequence(10);
        applyStimulus(1'b0, 10);

        // Bounced sequence, first run.
        build_expected_b(3, 20, done_b1);
        applyStimulus(1'b1, 20);

        // Press in hold cycle 3 is ignored; press in the done cycle restarts.
        push_a_sequence(40);
        applyStimulus(1'b0, 40);
        applyStimulus(1'b0, 43);
        push_a_sequence(56);
        applyStimulus(1'b0, 56);

        // Reset during hold aborts the sequence without a done pulse.
        exp_a.push_back(pack_ev(81, 1'b1, 1'b1, 1'b0));
        exp_a.push_back(pack_ev(86, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b0, 80);
        waitUntil(85);
        rst_a_n = 1'b0;
        waitUntil(86);
        rst_a_n = 1'b1;
        waitUntil(130);
        checkOutput("dut_a queue drained", 44'(exp_a.size()), 44'(0));

        waitUntil(done_b1 + 10);
        checkOutput("dut_b run1 queue drained", 44'(exp_b.size()), 44'(0));

        // Second run from a fresh reset must reproduce the same waveform.
        rst_b_n = 1'b0;
        waitUntil(done_b1 + 13);
        rst_b_n = 1'b1;
        r2 = done_b1 + 13;
        checkOutput("reset2 lfsr_b", 44'(dut_b.lfsr_q), 44'(16'hACE1));
        build_expected_b(r2, r2 + 17, done_b2);
        applyStimulus(1'b1, r2 + 17);
        waitUntil(done_b2 + 10);
        checkOutput("dut_b run2 queue drained", 44'(exp_b.size()), 44'(0));
        checkOutput("dut_b run2 length", 44'(done_b2 - r2), 44'(done_b1 - 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
